cordic_vectoring: RTL and testbench

Iterative CORDIC in vectoring mode. It is the inverse companion of the team's iterative rotation-mode CORDIC.
- Takes a Cartesian vector (x, y) and drives y to zero over ITER micro-rotations.
- Returns the gain-scaled magnitude K*sqrt(x²+y²), with K≈1.64676, and the angle atan2(y, x).
- Sits between sample sources and the phase/magnitude consumers, using valid/ready handshakes on both sides.

---
 rtl/cordic_vectoring_pkg.sv | 24 ++
 rtl/cordic_vectoring_if.sv | 25 ++
 rtl/cordic_vec_stage.sv | 36 +++
 rtl/cordic_vectoring.sv | 138 +++++++++++++
 tb/tb_cordic_vectoring.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/cordic_vectoring_pkg.sv
// Shared definitions for the CORDIC vectoring engine: default widths,
// quadrant constant, arctangent table and controller states.
package cordic_pkg;

  localparam int W_DEF   = 17;
  localparam int AW_DEF  = 18;
  localparam int HALF_PI = 51472;

  // atan(2^-i) in units where 32768 = 1.0 rad
  localparam logic signed [AW_DEF-1:0] ATAN_TABLE [0:15] = '{
    18'sd25735, 18'sd15192, 18'sd8027, 18'sd4075,
    18'sd2045,  18'sd1024,  18'sd512,  18'sd256,
    18'sd128,   18'sd64,    18'sd32,   18'sd16,
    18'sd8,     18'sd4,     18'sd2,    18'sd1
  };

  // Literals carry an ST_ prefix so they cannot collide with the ITER parameter
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cordic_vectoring_if.sv
// Sample-in / result-out handshake bundle for cordic_vectoring.
interface cordic_vectoring_if #(
  parameter int W  = 17,
  parameter int AW = 18,
  parameter int XW = W + 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  x_i;
  logic signed [W-1:0]  y_i;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [XW-1:0] mag_o;
  logic signed [AW-1:0] ang_o;

  modport master (
    output in_valid, x_i, y_i, out_ready,
    input  in_ready, out_valid, mag_o, ang_o
  );

  modport slave (
    input  in_valid, x_i, y_i, out_ready,
    output in_ready, out_valid, mag_o, ang_o
  );
endinterface

// File: rtl/cordic_vec_stage.sv
// One combinational vectoring micro-rotation: rotates (x, y) toward the
// positive x axis by atan(2^-i) and accumulates the rotation into z.
module cordic_vec_stage #(
  parameter int XW = 19,
  parameter int AW = 18,
  parameter int IW = 4
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [AW-1:0] z,
  input  logic        [IW-1:0] i,
  input  logic signed [AW-1:0] atan_i,
  output logic signed [XW-1:0] x_n,
  output logic signed [XW-1:0] y_n,
  output logic signed [AW-1:0] z_n
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;

  // Direction chosen by the sign of y; both updates use the pre-update x/y
  always_comb begin
    x_sh = x >>> i;
    y_sh = y >>> i;
    if (!y[XW-1]) begin
      x_n = x + y_sh;
      y_n = y - x_sh;
      z_n = z + atan_i;
    end else begin
      x_n = x - y_sh;
      y_n = y + x_sh;
      z_n = z - atan_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC, vectoring mode: returns K*|v| and atan2(y, x) for a
// Cartesian sample, one micro-rotation per clock.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int ITER = 16,
  parameter int AW   = AW_DEF,
  parameter int XW   = W + 2
) (
  input logic clk,
  input logic rst,
  cordic_vectoring_if.slave io
);

  localparam logic [3:0]           LAST_CNT = 4'(ITER - 1);
  localparam logic signed [AW-1:0] HALF_PI_A = AW'(HALF_PI);

  state_t               state;
  logic [3:0]           cnt;
  logic signed [XW-1:0] x_r;
  logic signed [XW-1:0] y_r;
  logic signed [AW-1:0] z_r;
  logic                 zero_r;
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic signed [XW-1:0] mag_r;
  logic signed [AW-1:0] ang_r;

  logic signed [XW-1:0] x_ext;
  logic signed [XW-1:0] y_ext;
  logic signed [XW-1:0] x_pre;
  logic signed [XW-1:0] y_pre;
  logic signed [AW-1:0] z_pre;
  logic signed [AW-1:0] atan_cur;
  logic signed [XW-1:0] x_nx;
  logic signed [XW-1:0] y_nx;
  logic signed [AW-1:0] z_nx;

  // Quadrant pre-rotation into the right half-plane; negation at XW width
  // so the most negative input cannot overflow
  always_comb begin
    x_ext = XW'(io.x_i);
    y_ext = XW'(io.y_i);
    if (!x_ext[XW-1]) begin
      x_pre = x_ext;
      y_pre = y_ext;
      z_pre = '0;
    end else if (!y_ext[XW-1]) begin
      x_pre = y_ext;
      y_pre = -x_ext;
      z_pre = HALF_PI_A;
    end else begin
      x_pre = -y_ext;
      y_pre = x_ext;
      z_pre = -HALF_PI_A;
    end
  end

  // Table entry for the current iteration, sign-extended to AW
  always_comb begin
    atan_cur = AW'(ATAN_TABLE[cnt]);
  end

  cordic_vec_stage #(
    .XW(XW),
    .AW(AW),
    .IW(4)
  ) u_stage (
    .x     (x_r),
    .y     (y_r),
    .z     (z_r),
    .i     (cnt),
    .atan_i(atan_cur),
    .x_n   (x_nx),
    .y_n   (y_nx),
    .z_n   (z_nx)
  );

  // Control FSM, iteration counter, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      mag_r       <= '0;
      ang_r       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.in_valid && in_ready_r) begin
            x_r        <= x_pre;
            y_r        <= y_pre;
            z_r        <= z_pre;
            zero_r     <= (io.x_i == '0) && (io.y_i == '0);
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= ST_ITER;
          end
        end
        ST_ITER: begin
          x_r <= x_nx;
          y_r <= y_nx;
          // A zero vector has no defined angle; keep z at 0
          if (!zero_r) z_r <= z_nx;
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            mag_r       <= x_nx;
            ang_r       <= zero_r ? z_r : z_nx;
            out_valid_r <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (io.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = in_ready_r;
  assign io.out_valid = out_valid_r;
  assign io.mag_o     = mag_r;
  assign io.ang_o     = ang_r;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed test of cordic_vectoring: reset state, latency, quadrant cases,
// zero input, extreme input, backpressure and mid-operation reset.
module tb_cordic_vectoring;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  logic signed [18:0] m_hold;
  logic signed [17:0] a_hold;

  cordic_vectoring_if #(.W(17), .AW(18), .XW(19)) io ();

  cordic_vectoring #(
    .W   (17),
    .ITER(16),
    .AW  (18),
    .XW  (19)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp, input int tol);
    checks++;
    assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  task automatic accept(input int x, input int y);
    @(negedge clk);
    io.in_valid = 1'b1;
    io.x_i      = 17'(x);
    io.y_i      = 17'(y);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    check_eq("accept_in_ready_low", io.in_ready, 0);
  endtask

  task automatic run_sample(input int x, input int y, output int latency);
    accept(x, y);
    latency = 0;
    while (latency < 40 && io.out_valid !== 1'b1) begin
      @(posedge clk);
      #1;
      latency++;
    end
    check_eq("latency", latency, 16);
  endtask

  task automatic release_out();
    @(negedge clk);
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    check_eq("release_out_valid", io.out_valid, 0);
    check_eq("release_in_ready", io.in_ready, 1);
  endtask

  initial begin
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    io.x_i       = '0;
    io.y_i       = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", io.in_ready, 1);
    check_eq("rst_out_valid", io.out_valid, 0);
    check_eq("rst_mag", io.mag_o, 0);
    check_eq("rst_ang", io.ang_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // positive x axis
    run_sample(10000, 0, lat);
    check_near("xaxis_mag", io.mag_o, 16468, 4);
    check_near("xaxis_ang", io.ang_o, 0, 4);
    release_out();

    // first-quadrant diagonal, then backpressure with a spurious sample
    run_sample(10000, 10000, lat);
    check_near("diag_mag", io.mag_o, 23289, 6);
    check_near("diag_ang", io.ang_o, 25736, 4);
    m_hold = io.mag_o;
    a_hold = io.ang_o;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      io.x_i      = 17'sd1234;
      io.y_i      = -17'sd4321;
      @(posedge clk);
      #1;
      check_eq("hold_out_valid", io.out_valid, 1);
      check_eq("hold_in_ready", io.in_ready, 0);
      check_eq("hold_mag", io.mag_o, m_hold);
      check_eq("hold_ang", io.ang_o, a_hold);
    end
    io.in_valid = 1'b0;
    release_out();

    // negative x axis
    run_sample(-10000, 0, lat);
    check_near("negx_mag", io.mag_o, 16468, 6);
    check_near("negx_ang", io.ang_o, 102944, 4);
    m_hold = io.mag_o;
    a_hold = io.ang_o;
    @(posedge clk);
    #1;
    check_eq("negx_mag_stable", io.mag_o, m_hold);
    check_eq("negx_ang_stable", io.ang_o, a_hold);
    check_eq("negx_valid_stable", io.out_valid, 1);
    release_out();

    // negative y axis
    run_sample(0, -10000, lat);
    check_near("negy_mag", io.mag_o, 16468, 6);
    check_near("negy_ang", io.ang_o, -51472, 4);
    m_hold = io.mag_o;
    a_hold = io.ang_o;
    @(posedge clk);
    #1;
    check_eq("negy_mag_stable", io.mag_o, m_hold);
    check_eq("negy_ang_stable", io.ang_o, a_hold);
    release_out();

    // zero vector
    run_sample(0, 0, lat);
    check_eq("zero_mag", io.mag_o, 0);
    check_eq("zero_ang", io.ang_o, 0);
    release_out();

    // most negative corner
    run_sample(-65536, -65536, lat);
    check_near("corner_mag", io.mag_o, 152622, 10);
    check_near("corner_ang", io.ang_o, -77208, 4);
    release_out();

    // reset during iteration 7 aborts the sample
    accept(12345, 6789);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_out_valid", io.out_valid, 0);
    check_eq("midrst_mag", io.mag_o, 0);
    check_eq("midrst_ang", io.ang_o, 0);
    check_eq("midrst_in_ready", io.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    // fresh sample after the abort
    run_sample(10000, 0, lat);
    check_near("after_rst_mag", io.mag_o, 16468, 4);
    check_near("after_rst_ang", io.ang_o, 0, 4);
    release_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
